// File: rtl/draw_pkg.sv
// Shared definitions for the line-drawing front end: default coordinate widths,
// command-word layout and segment-word field offsets.
package draw_pkg;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_X_W   = 9;
  localparam int DEF_Y_W   = 8;

  // Pen bit of a command word; 1 = draw a line, 0 = move only.
  typedef enum logic {
    PEN_UP   = 1'b0,
    PEN_DOWN = 1'b1
  } pen_e;

  // Command word: {pen, x, y}; the pen bit sits just above the coordinates.
  function automatic int pen_bit(input int xw, input int yw);
    return xw + yw;
  endfunction

  // Segment word: {x_from, y_from, x_to, y_to}, x_from in the MSBs.
  function automatic int seg_width(input int xw, input int yw);
    return 2 * (xw + yw);
  endfunction

  function automatic int off_y_to(input int xw, input int yw);
    return 0 * (xw + yw);
  endfunction

  function automatic int off_x_to(input int xw, input int yw);
    return yw + 0 * xw;
  endfunction

  function automatic int off_y_from(input int xw, input int yw);
    return xw + yw;
  endfunction

  function automatic int off_x_from(input int xw, input int yw);
    return xw + 2 * yw;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output and synchronous flush.
// The head entry is visible on rd_data whenever valid is high; rd_data reads
// as zero while empty so downstream sees clean outputs after reset/flush.
module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (level != '0);
  assign full    = (level == FULL_LVL);
  // Flush wins over both sides; a push into a full FIFO is ignored.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && valid && !flush;
  assign rd_data = valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; stale entries are never
    // observable because rd_data is masked by valid, and a reset-free array
    // maps onto RAM/LUT storage.
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/draw_cmd_queue.sv
// Pen-command front end of the line-drawing engine: decodes move/draw
// commands, tracks the pen position and queues line segments for the engine.
// Optional build macro DRAW_CMD_QUEUE_DROP_CNT_EN: no backpressure (cmd_ready
// tied 1); draws arriving while full are dropped and counted on drop_cnt.
module draw_cmd_queue
  import draw_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int X_W   = DEF_X_W,
  parameter int Y_W   = DEF_Y_W
) (
  input  logic                   clk50,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [X_W+Y_W:0]       cmd_data,
  output logic                   seg_valid,
  input  logic                   seg_ready,
  output logic [X_W-1:0]         x_from,
  output logic [Y_W-1:0]         y_from,
  output logic [X_W-1:0]         x_to,
  output logic [Y_W-1:0]         y_to,
  output logic [$clog2(DEPTH):0] level
`ifdef DRAW_CMD_QUEUE_DROP_CNT_EN
  ,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int PEN_B = pen_bit(X_W, Y_W);
  localparam int SEG_W = seg_width(X_W, Y_W);

  pen_e             cmd_pen;
  logic [X_W-1:0]   cmd_x;
  logic [Y_W-1:0]   cmd_y;
  logic [X_W-1:0]   pen_x;
  logic [Y_W-1:0]   pen_y;
  logic             accept;
  logic             zero_len;
  logic             want_push;
  logic             fifo_push;
  logic             fifo_full;
  logic [SEG_W-1:0] seg_data;
  logic [SEG_W-1:0] new_seg;

  assign cmd_pen  = pen_e'(cmd_data[PEN_B]);
  assign cmd_x    = cmd_data[Y_W +: X_W];
  assign cmd_y    = cmd_data[0 +: Y_W];
  assign zero_len = (cmd_x == pen_x) && (cmd_y == pen_y);
  assign new_seg  = {pen_x, pen_y, cmd_x, cmd_y};

  // A zero-length draw is accepted but produces no segment.
  assign want_push = accept && (cmd_pen == PEN_DOWN) && !zero_len;

`ifdef DRAW_CMD_QUEUE_DROP_CNT_EN
  logic drop;

  assign cmd_ready = 1'b1;
  assign accept    = cmd_valid;
  assign fifo_push = want_push && !fifo_full;
  // Flush takes the cycle, so a draw lost to the flush is not a drop.
  assign drop      = want_push && fifo_full && !flush;

  // Saturating count of draws discarded because the queue was full.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  logic ready_q;

  // Holds cmd_ready low through reset and for the release cycle.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  // Full comes from the registered level, so a same-cycle pop frees nothing.
  assign cmd_ready = ready_q && !fifo_full && !flush;
  assign accept    = cmd_valid && cmd_ready;
  assign fifo_push = want_push;
`endif

  // Pen position follows every accepted command (zero-length draws leave it
  // at the same value); flush does not touch it.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      pen_x <= '0;
      pen_y <= '0;
    end else if (accept) begin
      pen_x <= cmd_x;
      pen_y <= cmd_y;
    end
  end

  sync_fifo #(
    .WIDTH (SEG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk50),
    .rst     (rst),
    .flush   (flush),
    .push    (fifo_push),
    .wr_data (new_seg),
    .pop     (seg_ready),
    .rd_data (seg_data),
    .valid   (seg_valid),
    .full    (fifo_full),
    .level   (level)
  );

  assign x_from = seg_data[off_x_from(X_W, Y_W) +: X_W];
  assign y_from = seg_data[off_y_from(X_W, Y_W) +: Y_W];
  assign x_to   = seg_data[off_x_to(X_W, Y_W)   +: X_W];
  assign y_to   = seg_data[off_y_to(X_W, Y_W)   +: Y_W];

endmodule

// File: tb/tb_draw_cmd_queue.sv
// Self-checking bench for draw_cmd_queue: stimulus pushes expected segments
// into a scoreboard queue; a monitor pops and compares on every handshake.
module tb_draw_cmd_queue;

  logic        clk50 = 1'b0;
  logic        rst;
  logic        flush;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [17:0] cmd_data;
  logic        seg_valid;
  logic        seg_ready;
  logic [8:0]  x_from;
  logic [7:0]  y_from;
  logic [8:0]  x_to;
  logic [7:0]  y_to;
  logic [4:0]  level;
`ifdef DRAW_CMD_QUEUE_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [33:0] exp_q[$];
  logic [8:0]  model_x = '0;
  logic [7:0]  model_y = '0;

  draw_cmd_queue dut (
    .clk50     (clk50),
    .rst       (rst),
    .flush     (flush),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .seg_valid (seg_valid),
    .seg_ready (seg_ready),
    .x_from    (x_from),
    .y_from    (y_from),
    .x_to      (x_to),
    .y_to      (y_to),
    .level     (level)
`ifdef DRAW_CMD_QUEUE_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk50 = ~clk50;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every handshake must match the oldest expected segment.
  initial begin
    forever begin
      @(negedge clk50);
      if (!rst && !flush && seg_valid && seg_ready) begin
        if (exp_q.size() == 0) begin
          check("seg_unexpected", {30'd0, x_from, y_from, x_to, y_to}, 64'hDEAD);
        end else begin
          check("seg_data", {30'd0, x_from, y_from, x_to, y_to}, {30'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Offer one command, wait (bounded) for cmd_ready, update the pen model.
  task automatic send_cmd(input logic pen, input logic [8:0] x, input logic [7:0] y);
    bit done = 1'b0;
    cmd_data  = {pen, x, y};
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk50);
      if (cmd_ready) done = 1'b1;
    end
    check("cmd_accept", {63'd0, done}, 64'd1);
    if (done) begin
      if (pen && !(x == model_x && y == model_y))
        exp_q.push_back({model_x, model_y, x, y});
      model_x = x;
      model_y = y;
      @(posedge clk50);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    seg_ready = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk50);
      #1;
      if (level == 0) ok = 1'b1;
    end
    seg_ready = 1'b0;
    check("drain_done", {63'd0, ok}, 64'd1);
    check("drain_seg_valid", {63'd0, seg_valid}, 64'd0);
  endtask

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

`ifdef DRAW_CMD_QUEUE_DROP_CNT_EN
  localparam logic READY_IN_RST = 1'b1;
`else
  localparam logic READY_IN_RST = 1'b0;
`endif

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    seg_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_seg_valid", {63'd0, seg_valid}, 64'd0);
    check("rst_level", {59'd0, level}, 64'd0);
    check("rst_cmd_ready", {63'd0, cmd_ready}, {63'd0, READY_IN_RST});
    check("rst_seg_bus", {30'd0, x_from, y_from, x_to, y_to}, 64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // Move then draw: one segment visible right after the accepting edge
    seg_ready = 1'b1;
    send_cmd(1'b0, 9'd10, 8'd20);
    check("move_no_push", {59'd0, level}, 64'd0);
    send_cmd(1'b1, 9'd100, 8'd50);
    check("draw_latency_valid", {63'd0, seg_valid}, 64'd1);
    check("draw_latency_level", {59'd0, level}, 64'd1);
    check("draw_latency_bus", {30'd0, x_from, y_from, x_to, y_to},
          {30'd0, 9'd10, 8'd20, 9'd100, 8'd50});
    tick();
    check("draw_popped_level", {59'd0, level}, 64'd0);
    seg_ready = 1'b0;

    // Zero-length draw pushes nothing
    send_cmd(1'b0, 9'd0, 8'd0);
    send_cmd(1'b1, 9'd5, 8'd5);
    send_cmd(1'b1, 9'd5, 8'd5);
    check("zero_len_level", {59'd0, level}, 64'd1);
    drain();

    // Fill to DEPTH with the engine stalled
    for (int i = 0; i < 16; i++) send_cmd(1'b1, 9'(20 + i * 7), 8'(60 + i));
    check("full_level", {59'd0, level}, 64'd16);
`ifdef DRAW_CMD_QUEUE_DROP_CNT_EN
    check("full_cmd_ready_tied", {63'd0, cmd_ready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      cmd_data  = {1'b1, 9'(400 + i), 8'(10 + i)};
      cmd_valid = 1'b1;
      tick();
      model_x = 9'(400 + i);
      model_y = 8'(10 + i);
    end
    cmd_valid = 1'b0;
    check("drop_cnt", {48'd0, drop_cnt}, 64'd3);
    check("drop_level", {59'd0, level}, 64'd16);
`else
    check("full_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    cmd_data  = {1'b1, 9'd300, 8'd200};
    cmd_valid = 1'b1;
    tick();
    check("full_held_off", {59'd0, level}, 64'd16);
    // Pop with a command pending: pop only, ready returns the next cycle
    seg_ready = 1'b1;
    tick();
    seg_ready = 1'b0;
    check("full_pop_only_level", {59'd0, level}, 64'd15);
    check("full_ready_rises", {63'd0, cmd_ready}, 64'd1);
    exp_q.push_back({model_x, model_y, 9'd300, 8'd200});
    model_x = 9'd300;
    model_y = 8'd200;
    tick();
    cmd_valid = 1'b0;
    check("refill_level", {59'd0, level}, 64'd16);
`endif
    drain();

    // Flush with level 7: queue emptied, pen position kept
    for (int i = 0; i < 7; i++) send_cmd(1'b1, 9'(200 + i), 8'(100 + i));
    check("pre_flush_level", {59'd0, level}, 64'd7);
    flush = 1'b1;
`ifndef DRAW_CMD_QUEUE_DROP_CNT_EN
    cmd_data  = {1'b1, 9'd250, 8'd250};
    cmd_valid = 1'b1;
    #1;
    check("flush_cmd_ready", {63'd0, cmd_ready}, 64'd0);
`endif
    tick();
    flush     = 1'b0;
    cmd_valid = 1'b0;
    exp_q.delete();
    check("flush_level", {59'd0, level}, 64'd0);
    check("flush_seg_valid", {63'd0, seg_valid}, 64'd0);
    send_cmd(1'b1, 9'd33, 8'd44);
    check("flush_pen_kept", {30'd0, x_from, y_from, x_to, y_to},
          {30'd0, 9'd206, 8'd106, 9'd33, 8'd44});
    drain();

    // Reset mid-traffic discards queued segments and the pen position
    for (int i = 0; i < 3; i++) send_cmd(1'b1, 9'(1 + i), 8'(1 + i));
    rst = 1'b1;
    #1;
    check("midrst_seg_valid", {63'd0, seg_valid}, 64'd0);
    repeat (3) tick();
    check("midrst_level", {59'd0, level}, 64'd0);
    check("midrst_cmd_ready", {63'd0, cmd_ready}, {63'd0, READY_IN_RST});
    exp_q.delete();
    model_x = '0;
    model_y = '0;
    rst = 1'b0;
    tick();
    check("midrst_ready_after", {63'd0, cmd_ready}, 64'd1);
    send_cmd(1'b1, 9'd1, 8'd2);
    check("midrst_pen_origin", {30'd0, x_from, y_from, x_to, y_to},
          {30'd0, 9'd0, 8'd0, 9'd1, 8'd2});
    drain();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
